// File: rtl/pe_array_stream.sv
// NUM_PE-lane signed MAC array with a valid/ready front end, first/last framing,
// a two-stage saturating multiply/accumulate pipeline and a backpressured output register.
module pe_array_stream #(
  parameter int NUM_PE = 4,
  parameter int A_W    = 16,
  parameter int W_W    = 8,
  parameter int ACC_W  = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    relu_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic                    in_pad,
  input  logic [A_W-1:0]          din_a,
  input  logic [NUM_PE*W_W-1:0]   din_w,
  input  logic [NUM_PE*ACC_W-1:0] bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_PE*ACC_W-1:0] dout,
  output logic                    err_seq
);

  localparam int P_W = A_W + W_W;

  logic           en;
  logic           accept;
  logic           adv;
  logic           load_out;
  logic [A_W-1:0] a_eff;

  logic s1_valid_reg;
  logic s1_first_reg;
  logic s1_last_reg;
  logic open_reg;
  logic out_valid_reg;
  logic err_seq_reg;

  // The whole pipeline freezes only while a finished result is waiting on downstream.
  assign en       = !(out_valid_reg && !out_ready);
  assign in_ready = en;
  assign accept   = en && in_valid;
  assign adv      = en && s1_valid_reg;
  assign load_out = adv && s1_last_reg;
  assign a_eff    = in_pad ? '0 : din_a;

  assign out_valid = out_valid_reg;
  assign err_seq   = err_seq_reg;

  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_valid_reg  <= 1'b0;
      s1_first_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      open_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      err_seq_reg   <= 1'b0;
    end else begin
      if (en) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_first_reg <= in_first;
          s1_last_reg  <= in_last;
        end
      end
      if (adv) begin
        open_reg <= !s1_last_reg;
        // first while open, or continuation while closed, are both framing errors
        if (s1_first_reg == open_reg) begin
          err_seq_reg <= 1'b1;
        end
      end
      if (load_out) begin
        out_valid_reg <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_lane
      logic [W_W-1:0]   w_lane;
      logic [P_W-1:0]   prod_full;
      logic [ACC_W-1:0] prod_next;
      logic [ACC_W-1:0] prod_reg;
      logic [ACC_W-1:0] bias_reg;
      logic [ACC_W-1:0] acc_reg;
      logic [ACC_W-1:0] dout_reg;
      logic [ACC_W-1:0] base;
      logic [ACC_W:0]   sum_wide;
      logic [ACC_W-1:0] acc_next;
      logic [ACC_W-1:0] out_next;

      assign w_lane = din_w[gi*W_W +: W_W];
      // Sign-extended operands give the exact signed product modulo 2^P_W, which always fits.
      assign prod_full = {{W_W{a_eff[A_W-1]}}, a_eff} * {{A_W{w_lane[W_W-1]}}, w_lane};
      assign prod_next = {{(ACC_W-P_W){prod_full[P_W-1]}}, prod_full};

      assign base     = s1_first_reg ? bias_reg : acc_reg;
      assign sum_wide = {base[ACC_W-1], base} + {prod_reg[ACC_W-1], prod_reg};

      always_comb begin
        acc_next = sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
          acc_next = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
      end

      assign out_next = (relu_en && acc_next[ACC_W-1]) ? '0 : acc_next;

      always_ff @(posedge aclk) begin
        if (areset) begin
          prod_reg <= '0;
          bias_reg <= '0;
          acc_reg  <= '0;
          dout_reg <= '0;
        end else begin
          if (accept) begin
            prod_reg <= prod_next;
          end
          if (accept && in_first) begin
            bias_reg <= bias[gi*ACC_W +: ACC_W];
          end
          if (adv) begin
            acc_reg <= acc_next;
          end
          if (load_out) begin
            dout_reg <= out_next;
          end
        end
      end

      assign dout[gi*ACC_W +: ACC_W] = dout_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pe_array_stream.sv
// Directed bench for pe_array_stream (NUM_PE=4, A_W=16, W_W=8, ACC_W=32) with
// hand-computed expected result vectors.
module tb_pe_array_stream;

  logic         aclk;
  logic         areset;
  logic         relu_en;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic         in_last;
  logic         in_pad;
  logic [15:0]  din_a;
  logic [31:0]  din_w;
  logic [127:0] bias;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;
  logic         err_seq;

  int checks = 0;
  int errors = 0;
  logic [127:0] res;
  logic [127:0] got[$];

  pe_array_stream #(.NUM_PE(4), .A_W(16), .W_W(8), .ACC_W(32)) dut (
    .aclk(aclk), .areset(areset), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_last(in_last), .in_pad(in_pad), .din_a(din_a), .din_w(din_w),
    .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .err_seq(err_seq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [31:0] pw(input int w0, input int w1, input int w2, input int w3);
    return {w3[7:0], w2[7:0], w1[7:0], w0[7:0]};
  endfunction

  function automatic logic [127:0] pk(input int v0, input int v1, input int v2, input int v3);
    return {v3, v2, v1, v0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic beat(input logic f, input logic l, input logic p, input int a,
                      input logic [31:0] w, input logic [127:0] b);
    int n;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_pad   = p;
    din_a    = a[15:0];
    din_w    = w;
    bias     = b;
    n = 0;
    @(negedge aclk);
    while (!in_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!in_ready) chk("beat_accept_timeout", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    in_pad   = 1'b0;
  endtask

  task automatic get_result(input string tag, output logic [127:0] r);
    int n;
    n = 0;
    @(negedge aclk);
    while (!out_valid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 128'(out_valid), 128'(1));
    r = dout;
    $display("result %s: dout=%h err_seq=%0b", tag, dout, err_seq);
    step();
  endtask

  initial begin
    areset = 1'b1; relu_en = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_pad = 1'b0; din_a = '0; din_w = '0; bias = '0; out_ready = 1'b1;
    step();
    step();
    areset = 1'b0;

    @(negedge aclk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_dout", dout, '0);
    chk("rst_err_seq", 128'(err_seq), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // Single-beat dot product, latency and one-cycle valid
    step();
    beat(1, 1, 0, 100, pw(1, -2, 3, -4), pk(10, 0, 0, -5));
    @(negedge aclk);
    chk("single_t1_valid", 128'(out_valid), 128'(0));
    @(negedge aclk);
    chk("single_t2_valid", 128'(out_valid), 128'(1));
    chk("single_dout", dout, pk(110, -200, 300, -405));
    @(negedge aclk);
    chk("single_t3_valid", 128'(out_valid), 128'(0));

    // Three-beat dot product
    step();
    beat(1, 0, 0, 2, pw(5, 1, 0, -1), pk(1, 0, 100, -3));
    beat(0, 0, 0, 3, pw(6, 1, 0, -1), '0);
    beat(0, 1, 0, 4, pw(7, 1, 0, -1), '0);
    get_result("three_beat", res);
    chk("three_beat_dout", res, pk(57, 9, 100, -12));
    chk("three_beat_err", 128'(err_seq), 128'(0));

    // Padded middle beat
    beat(1, 0, 0, 2, pw(5, 1, 0, -1), pk(1, 0, 100, -3));
    beat(0, 0, 1, 3, pw(6, 1, 0, -1), '0);
    beat(0, 1, 0, 4, pw(7, 1, 0, -1), '0);
    get_result("pad", res);
    chk("pad_dout", res, pk(39, 6, 100, -9));

    // ReLU clamps negative results
    relu_en = 1'b1;
    beat(1, 0, 0, 2, pw(-1, -1, -1, -1), pk(1, 1, 1, 1));
    beat(0, 0, 0, 3, pw(-1, -1, -1, -1), '0);
    beat(0, 1, 0, 4, pw(-1, -1, -1, -1), '0);
    get_result("relu", res);
    chk("relu_dout", res, '0);
    relu_en = 1'b0;

    // Saturation at both rails, no wrap
    beat(1, 0, 0, 32767, pw(127, -128, 1, 0), pk(32'h7FFFFF00, 32'h80000100, 0, 5));
    beat(0, 1, 0, 32767, pw(127, -128, 1, 0), '0);
    get_result("sat", res);
    chk("sat_dout", res, pk(32'h7FFFFFFF, 32'h80000000, 65534, 5));

    // Backpressure: result held, input stalled, next result not lost
    out_ready = 1'b0;
    beat(1, 1, 0, 1, pw(1, 1, 1, 1), '0);
    beat(1, 1, 0, 2, pw(1, 1, 1, 1), '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("bp_hold_valid", 128'(out_valid), 128'(1));
      chk("bp_hold_in_ready", 128'(in_ready), 128'(0));
      chk("bp_hold_dout", dout, pk(1, 1, 1, 1));
      step();
    end
    out_ready = 1'b1;
    @(negedge aclk);
    chk("bp_release_in_ready", 128'(in_ready), 128'(1));
    chk("bp_release_dout", dout, pk(1, 1, 1, 1));
    step();
    @(negedge aclk);
    chk("bp_next_valid", 128'(out_valid), 128'(1));
    chk("bp_next_dout", dout, pk(2, 2, 2, 2));
    step();
    @(negedge aclk);
    chk("bp_drain_valid", 128'(out_valid), 128'(0));
    step();

    // Back-to-back single beats with out_ready toggling every cycle
    got.delete();
    fork
      begin
        for (int k = 0; k < 6; k++) beat(1, 1, 0, k + 1, pw(1, 2, 3, 4), '0);
      end
      begin
        int cyc;
        cyc = 0;
        while (got.size() < 6 && cyc < 200) begin
          @(negedge aclk);
          if (out_valid && out_ready) got.push_back(dout);
          step();
          out_ready = ~out_ready;
          cyc++;
        end
      end
    join
    out_ready = 1'b1;
    chk("toggle_count", 128'(got.size()), 128'(6));
    for (int k = 0; k < got.size(); k++) begin
      $display("toggle result %0d: dout=%h", k, got[k]);
      chk("toggle_dout", got[k], pk(k + 1, 2 * (k + 1), 3 * (k + 1), 4 * (k + 1)));
    end
    repeat (3) @(negedge aclk);
    chk("toggle_no_extra", 128'(out_valid), 128'(0));
    step();

    // Framing error: restart before last
    beat(1, 0, 0, 10, pw(1, 1, 1, 1), '0);
    beat(1, 0, 0, 3, pw(1, 1, 1, 1), pk(5, 5, 5, 5));
    beat(0, 1, 0, 2, pw(1, 1, 1, 1), '0);
    get_result("restart", res);
    chk("restart_dout", res, pk(10, 10, 10, 10));
    chk("restart_err", 128'(err_seq), 128'(1));

    // Reset during beat 2 of 3
    beat(1, 0, 0, 2, pw(1, 1, 1, 1), '0);
    in_valid = 1'b1; in_first = 1'b0; in_last = 1'b0; din_a = 16'd3;
    areset = 1'b1;
    step();
    areset = 1'b0;
    in_valid = 1'b0;
    @(negedge aclk);
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_dout", dout, '0);
    chk("midrst_err", 128'(err_seq), 128'(0));
    repeat (3) @(negedge aclk);
    chk("midrst_no_emit", 128'(out_valid), 128'(0));
    step();
    beat(1, 1, 0, 9, pw(1, 2, 3, 4), '0);
    get_result("post_rst", res);
    chk("post_rst_dout", res, pk(9, 18, 27, 36));
    chk("post_rst_err", 128'(err_seq), 128'(0));

    // Continuation beat with no frame open after reset
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
    beat(0, 1, 0, 7, pw(1, 1, 1, 1), pk(100, 100, 100, 100));
    get_result("orphan", res);
    chk("orphan_dout", res, pk(7, 7, 7, 7));
    chk("orphan_err", 128'(err_seq), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
